// File: rtl/fifo_multi_pkg.sv
// Shared sizing helpers and parameter legality checks for the fifo_multi bank.
package fifo_multi_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointers wrap naturally only when DEPTH is a power of two.
  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned ae_level,
                                   input int unsigned af_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_multi_channel.sv
// One WIDTH x DEPTH synchronous FIFO with occupancy count, threshold flags and
// full-and-read pass-through; sticky error flags present with FIFO_MULTI_ERR_EN.
module fifo_channel
  import fifo_multi_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef FIFO_MULTI_ERR_EN
  input  logic                      err_clr,
  output logic                      overflow,
  output logic                      underflow,
`endif
  input  logic                      write,
  input  logic [WIDTH-1:0]          din,
  input  logic                      read,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      almost_full,
  output logic                      empty,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_acc_c, wr_acc_c;

  // A write to a full channel is accepted only when a read frees the slot on the same edge.
  always_comb begin
    rd_acc_c = read && (count_q != '0);
    wr_acc_c = write && ((count_q != CW'(DEPTH)) || rd_acc_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dout_d   = mem[rd_ptr_q];
    end
    if (wr_acc_c && !rd_acc_c) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout         = dout_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

`ifdef FIFO_MULTI_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Clear wins over a same-edge set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (write && !wr_acc_c) overflow_d  = 1'b1;
      if (read && !rd_acc_c)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: rtl/fifo_multi.sv
// Bank of NUM_CH independent synchronous FIFOs sharing clock and reset.
// Define FIFO_MULTI_ERR_EN to add sticky overflow/underflow flags and err_clr.
module fifo_multi
  import fifo_multi_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                write,
  input  logic [NUM_CH*WIDTH-1:0]          din,
  output logic [NUM_CH-1:0]                full,
  output logic [NUM_CH-1:0]                almost_full,
  input  logic [NUM_CH-1:0]                read,
  output logic [NUM_CH*WIDTH-1:0]          dout,
  output logic [NUM_CH-1:0]                empty,
  output logic [NUM_CH-1:0]                almost_empty,
`ifdef FIFO_MULTI_ERR_EN
  output logic [NUM_CH-1:0]                overflow,
  output logic [NUM_CH-1:0]                underflow,
  input  logic                             err_clr,
`endif
  output logic [NUM_CH*cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);

  if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL) || (NUM_CH < 1)) begin : g_param_err
    $error("fifo_multi: illegal DEPTH/AE_LEVEL/AF_LEVEL/NUM_CH combination");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_channel #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
`ifdef FIFO_MULTI_ERR_EN
      .err_clr      (err_clr),
      .overflow     (overflow[c]),
      .underflow    (underflow[c]),
`endif
      .write        (write[c]),
      .din          (din[c*WIDTH +: WIDTH]),
      .read         (read[c]),
      .dout         (dout[c*WIDTH +: WIDTH]),
      .full         (full[c]),
      .almost_full  (almost_full[c]),
      .empty        (empty[c]),
      .almost_empty (almost_empty[c]),
      .count        (count[c*CW +: CW])
    );
  end

endmodule

// File: tb/tb_fifo_multi.sv
// Directed, table-driven bench for fifo_multi (NUM_CH=2, DEPTH=4, WIDTH=8).
module tb_fifo_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write, read;
  logic [15:0] din;
  logic [15:0] dout;
  logic [1:0]  full, almost_full, empty, almost_empty;
  logic [5:0]  count;
`ifdef FIFO_MULTI_ERR_EN
  logic [1:0]  overflow, underflow;
  logic        err_clr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_multi #(
    .WIDTH(8), .DEPTH(4), .NUM_CH(2), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .din          (din),
    .full         (full),
    .almost_full  (almost_full),
    .read         (read),
    .dout         (dout),
    .empty        (empty),
    .almost_empty (almost_empty),
`ifdef FIFO_MULTI_ERR_EN
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr),
`endif
    .count        (count)
  );

  typedef struct {
    logic [1:0]  wr, rd;
    logic [7:0]  d0, d1;
    logic [15:0] dout;
    logic [5:0]  cnt;
    logic [1:0]  emp, ful, af, ae, ovf, udf;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic [1:0] wr, input logic [1:0] rd,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [15:0] dv, input logic [5:0] cnt,
                              input logic [1:0] emp, input logic [1:0] ful,
                              input logic [1:0] af, input logic [1:0] ae,
                              input logic [1:0] ovf, input logic [1:0] udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d0 = d0; v.d1 = d1; v.dout = dv; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.af = af; v.ae = ae; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int idx, input logic [15:0] edout,
                          input logic [5:0] ecnt, input logic [1:0] eemp,
                          input logic [1:0] eful, input logic [1:0] eaf,
                          input logic [1:0] eae);
    chk({tag, ".dout"},  idx, 32'(dout),         32'(edout));
    chk({tag, ".count"}, idx, 32'(count),        32'(ecnt));
    chk({tag, ".empty"}, idx, 32'(empty),        32'(eemp));
    chk({tag, ".full"},  idx, 32'(full),         32'(eful));
    chk({tag, ".afull"}, idx, 32'(almost_full),  32'(eaf));
    chk({tag, ".aempty"},idx, 32'(almost_empty), 32'(eae));
  endtask

  task automatic step(input logic [1:0] wr, input logic [1:0] rd,
                      input logic [7:0] d0, input logic [7:0] d1);
    write = wr;
    read  = rd;
    din   = {d1, d0};
    @(posedge clk);
    #1;
    write = '0;
    read  = '0;
  endtask

  initial begin
    // wr, rd, d0, d1, dout{ch1,ch0}, count{c1,c0}, empty, full, afull, aempty, ovf, udf
    vecs[0]  = mk(2'b01, 2'b00, 8'h01, 8'h00, 16'h0000, 6'o01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    vecs[1]  = mk(2'b01, 2'b00, 8'h02, 8'h00, 16'h0000, 6'o02, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    vecs[2]  = mk(2'b01, 2'b00, 8'h03, 8'h00, 16'h0000, 6'o03, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    vecs[3]  = mk(2'b01, 2'b00, 8'h04, 8'h00, 16'h0000, 6'o04, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00);
    vecs[4]  = mk(2'b01, 2'b01, 8'h05, 8'h00, 16'h0001, 6'o04, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00);
    vecs[5]  = mk(2'b01, 2'b00, 8'h09, 8'h00, 16'h0001, 6'o04, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00);
    vecs[6]  = mk(2'b00, 2'b01, 8'h00, 8'h00, 16'h0002, 6'o03, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00);
    vecs[7]  = mk(2'b00, 2'b01, 8'h00, 8'h00, 16'h0003, 6'o02, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00);
    vecs[8]  = mk(2'b00, 2'b01, 8'h00, 8'h00, 16'h0004, 6'o01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    vecs[9]  = mk(2'b00, 2'b01, 8'h00, 8'h00, 16'h0005, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    vecs[10] = mk(2'b00, 2'b01, 8'h00, 8'h00, 16'h0005, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01);
    vecs[11] = mk(2'b01, 2'b01, 8'h07, 8'h00, 16'h0005, 6'o01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01);
    vecs[12] = mk(2'b00, 2'b01, 8'h00, 8'h00, 16'h0007, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01);
    vecs[13] = mk(2'b10, 2'b00, 8'h00, 8'hA1, 16'h0007, 6'o10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01);
    vecs[14] = mk(2'b10, 2'b01, 8'h00, 8'hA2, 16'h0007, 6'o20, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
    vecs[15] = mk(2'b11, 2'b00, 8'h55, 8'hA3, 16'h0007, 6'o31, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01);
    vecs[16] = mk(2'b10, 2'b00, 8'h00, 8'hA4, 16'h0007, 6'o41, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01);
    vecs[17] = mk(2'b10, 2'b00, 8'h00, 8'hEE, 16'h0007, 6'o41, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01);
    vecs[18] = mk(2'b00, 2'b11, 8'h00, 8'h00, 16'hA155, 6'o30, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01);
    vecs[19] = mk(2'b00, 2'b10, 8'h00, 8'h00, 16'hA255, 6'o20, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01);
    vecs[20] = mk(2'b00, 2'b10, 8'h00, 8'h00, 16'hA355, 6'o10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01);
    vecs[21] = mk(2'b00, 2'b10, 8'h00, 8'h00, 16'hA455, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01);
    vecs[22] = mk(2'b00, 2'b10, 8'h00, 8'h00, 16'hA455, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);

    rst   = 1'b1;
    write = '0;
    read  = '0;
    din   = '0;
`ifdef FIFO_MULTI_ERR_EN
    err_clr = 1'b0;
`endif
    #12;
    chk_outs("reset", 0, 16'h0000, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11);
`ifdef FIFO_MULTI_ERR_EN
    chk("reset.ovf", 0, 32'(overflow),  32'(2'b00));
    chk("reset.udf", 0, 32'(underflow), 32'(2'b00));
`endif
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].d0, vecs[i].d1);
      chk_outs("vec", i, vecs[i].dout, vecs[i].cnt, vecs[i].emp, vecs[i].ful,
               vecs[i].af, vecs[i].ae);
`ifdef FIFO_MULTI_ERR_EN
      chk("vec.ovf", i, 32'(overflow),  32'(vecs[i].ovf));
      chk("vec.udf", i, 32'(underflow), 32'(vecs[i].udf));
`endif
    end

`ifdef FIFO_MULTI_ERR_EN
    // Clear, then clear racing a new underflow, then a fresh underflow.
    err_clr = 1'b1;
    step(2'b00, 2'b00, 8'h00, 8'h00);
    chk("clr.ovf", 0, 32'(overflow),  32'(2'b00));
    chk("clr.udf", 0, 32'(underflow), 32'(2'b00));
    step(2'b00, 2'b01, 8'h00, 8'h00);
    chk("clr_race.udf", 0, 32'(underflow), 32'(2'b00));
    err_clr = 1'b0;
    step(2'b00, 2'b01, 8'h00, 8'h00);
    chk("reset_udf.udf", 0, 32'(underflow), 32'(2'b01));
`endif

    // Fill ch0 to three words with a read outstanding, then reset mid-burst.
    step(2'b01, 2'b00, 8'h11, 8'h00);
    step(2'b01, 2'b00, 8'h22, 8'h00);
    step(2'b01, 2'b00, 8'h33, 8'h00);
    step(2'b01, 2'b00, 8'h44, 8'h00);
    step(2'b00, 2'b01, 8'h00, 8'h00);
    chk_outs("pre_rst", 0, 16'hA411, 6'o03, 2'b10, 2'b00, 2'b01, 2'b10);
    write = 2'b01;
    din   = 16'h0099;
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 0, 16'h0000, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11);
`ifdef FIFO_MULTI_ERR_EN
    chk("async_rst.udf", 0, 32'(underflow), 32'(2'b00));
`endif
    #2;
    write = '0;
    rst   = 1'b0;
    step(2'b01, 2'b00, 8'h66, 8'h00);
    chk_outs("post_rst_wr", 0, 16'h0000, 6'o01, 2'b10, 2'b00, 2'b00, 2'b11);
    step(2'b00, 2'b01, 8'h00, 8'h00);
    chk_outs("post_rst_rd", 0, 16'h0066, 6'o00, 2'b11, 2'b00, 2'b00, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
